// File: rtl/wb_tester_pkg.sv
// Shared definitions for the Wishbone memory tester.
// Contents: FSM state enum, data-pattern enum, Wishbone CTI codes,
// and the LFSR polynomial, seed and single-step helper.
package wb_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WR_BURST  = 3'd2,
    ST_WR_GAP    = 3'd3,
    ST_RD_BURST  = 3'd4,
    ST_RD_GAP    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PAT_ADDR = 2'd0,
    PAT_LFSR = 2'd1,
    PAT_WALK = 2'd2,
    PAT_INV  = 2'd3
  } pattern_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // x^32+x^22+x^2+x+1 as a right-shifting Galois tap mask.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

endpackage

// File: rtl/wb_mem_tester_if.sv
// Wishbone B3 bus bundle between the memory tester (master) and the
// memory controller port (slave).
// Signals: wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o,
// wb_cti_o (master driven); wb_ack_i, wb_dat_i (slave driven).
//
// Handshake: a beat transfers on a rising clock edge where wb_stb_o and
// wb_ack_i are both high. While wb_stb_o is high without wb_ack_i the
// master holds address, data, we, sel and cti stable. wb_ack_i is
// meaningless while wb_stb_o is low.
interface wb_mem_tester_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  localparam int BW = DW / 8;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [BW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_pattern_gen.sv
// Test-word generator shared by the write and read phases.
// Ports: i_clk, i_rst (sync, active-high); i_load reseeds the LFSR,
// i_step advances it one word; i_mode selects the pattern; i_idx is
// the word index; o_data is the word for that index.
module wb_pattern_gen
  import wb_tester_pkg::*;
#(
  parameter int DW = 32
)(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_step,
  input  pattern_t      i_mode,
  input  logic [15:0]   i_idx,
  output logic [DW-1:0] o_data
);
  localparam int LW = $clog2(DW);

  logic [31:0] r_lfsr;

  // Load wins over step so a reseed on the last beat of a phase is clean.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) r_lfsr <= LFSR_SEED;
    else if (i_step)     r_lfsr <= lfsr_step(r_lfsr);
  end

  // The index is zero-extended to DW before inversion, so the inverted
  // pattern has all upper bits set when DW > 16.
  always_comb begin
    o_data = '0;
    case (i_mode)
      PAT_ADDR: o_data = DW'(i_idx);
      PAT_LFSR: o_data = DW'(r_lfsr);
      PAT_WALK: o_data = DW'(1) << i_idx[LW-1:0];
      PAT_INV:  o_data = ~DW'(i_idx);
      default:  o_data = '0;
    endcase
  end
endmodule

// File: rtl/wb_mem_tester.sv
// Self-checking Wishbone B3 burst master: writes a pattern over a word
// window with incrementing bursts, reads it back and compares each word.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); start_i with cfg_base_i,
// cfg_words_i, cfg_pattern_i sampled on start; init_done_i gates the
// first burst; wb (master modport) is the bus; busy_o, done_o, pass_o,
// err_cnt_o, fail_addr_o, fail_data_o, timeout_o report status;
// dbg_state_o exposes the FSM state.
// Optional build macro WB_MEM_TESTER_TIMEOUT_EN adds an ack watchdog of
// TIMEOUT_CYC cycles; without it timeout_o is tied low.
module wb_mem_tester
  import wb_tester_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 26,
  parameter int BL          = 8,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] cfg_base_i,
  input  logic [15:0]   cfg_words_i,
  input  logic [1:0]    cfg_pattern_i,
  input  logic          init_done_i,
  wb_mem_tester_if.master wb,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [15:0]   err_cnt_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [DW-1:0] fail_data_o,
  output logic          timeout_o,
  output state_t        dbg_state_o
);
  localparam int BW = DW / 8;
  localparam int LB = $clog2(BW);

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_base;
  logic [15:0]   r_words, r_idx, r_err;
  pattern_t      r_pattern;
  logic [4:0]    r_beat, r_blen, w_blen_n;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_data;
  logic [15:0]   w_rem;
  logic [DW-1:0] w_pat;
  logic          w_accept, w_begin, w_reseed, w_in_burst, w_ack;
  logic          w_last_beat, w_last_word, w_mismatch, w_timeout;

  assign w_in_burst  = (r_state == ST_WR_BURST) || (r_state == ST_RD_BURST);
  assign w_ack       = w_in_burst && wb.wb_ack_i;
  assign w_last_beat = (r_beat == r_blen - 5'd1);
  assign w_last_word = (r_idx == r_words - 16'd1);
  assign w_mismatch  = (r_state == ST_RD_BURST) && wb.wb_ack_i && (wb.wb_dat_i != w_pat);

  // Words left for the burst about to start; the read phase restarts at 0.
  assign w_rem    = r_words - (w_reseed ? 16'd0 : r_idx);
  assign w_blen_n = (w_rem > 16'(BL)) ? 5'(BL) : w_rem[4:0];

`ifdef WB_MEM_TESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wd;
  logic          r_timeout;
  logic          w_abort;

  // Abort on the cycle that would make the TIMEOUT_CYC-th unacked stb cycle.
  assign w_abort = w_in_burst && !wb.wb_ack_i && (r_wd == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !w_in_burst || wb.wb_ack_i) r_wd <= '0;
    else                                          r_wd <= r_wd + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_accept) r_timeout <= 1'b0;
    else if (w_abort)         r_timeout <= 1'b1;
  end

  assign w_timeout = r_timeout;
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_begin   = 1'b0;
    w_reseed  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_accept  = 1'b1;
          w_state_n = (cfg_words_i == 16'd0) ? ST_DONE : ST_WAIT_INIT;
        end
      end
      ST_WAIT_INIT: begin
        if (init_done_i) begin
          w_begin   = 1'b1;
          w_state_n = ST_WR_BURST;
        end
      end
      ST_WR_BURST: if (w_ack && w_last_beat) w_state_n = ST_WR_GAP;
      ST_WR_GAP: begin
        w_begin = 1'b1;
        if (r_idx == r_words) begin
          w_reseed  = 1'b1;
          w_state_n = ST_RD_BURST;
        end else begin
          w_state_n = ST_WR_BURST;
        end
      end
      ST_RD_BURST: if (w_ack && w_last_beat) w_state_n = w_last_word ? ST_DONE : ST_RD_GAP;
      ST_RD_GAP: begin
        w_begin   = 1'b1;
        w_state_n = ST_RD_BURST;
      end
      default: w_state_n = ST_IDLE;
    endcase
`ifdef WB_MEM_TESTER_TIMEOUT_EN
    if (w_abort) w_state_n = ST_DONE;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_base      <= '0;
      r_words     <= '0;
      r_pattern   <= PAT_ADDR;
      r_idx       <= '0;
      r_beat      <= '0;
      r_blen      <= '0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      if (w_accept) begin
        r_base      <= cfg_base_i & ~AW'(BW - 1);
        r_words     <= cfg_words_i;
        r_pattern   <= pattern_t'(cfg_pattern_i);
        r_idx       <= '0;
        r_err       <= '0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end
      if (w_begin) begin
        r_beat <= '0;
        r_blen <= w_blen_n;
        if (w_reseed) r_idx <= '0;
      end
      if (w_ack) begin
        r_idx  <= r_idx + 16'd1;
        r_beat <= r_beat + 5'd1;
      end
      if (w_mismatch) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0) begin
          r_fail_addr <= wb.wb_addr_o;
          r_fail_data <= wb.wb_dat_i;
        end
      end
    end
  end

  wb_pattern_gen #(.DW(DW)) u_pat (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_load (w_accept | w_reseed),
    .i_step (w_ack),
    .i_mode (r_pattern),
    .i_idx  (r_idx),
    .o_data (w_pat)
  );

  assign wb.wb_cyc_o  = w_in_burst;
  assign wb.wb_stb_o  = w_in_burst;
  assign wb.wb_we_o   = (r_state == ST_WR_BURST);
  assign wb.wb_addr_o = r_base + (AW'(r_idx) << LB);
  assign wb.wb_dat_o  = w_pat;
  assign wb.wb_sel_o  = w_in_burst ? '1 : '0;
  assign wb.wb_cti_o  = (r_blen == 5'd1) ? CTI_CLASSIC : (w_last_beat ? CTI_EOB : CTI_INCR);

  assign busy_o      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done_o      = (r_state == ST_DONE);
  assign pass_o      = done_o && (r_err == 16'd0) && !w_timeout;
  assign err_cnt_o   = r_err;
  assign fail_addr_o = r_fail_addr;
  assign fail_data_o = r_fail_data;
  assign timeout_o   = w_timeout;
  assign dbg_state_o = r_state;
endmodule

// File: tb/tb_wb_mem_tester.sv
module tb_wb_mem_tester;
  import wb_tester_pkg::*;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int BL = 8;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [15:0]   cfg_words = '0;
  logic [1:0]    cfg_pat = '0;
  logic          init_done = 1'b0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  state_t        dbg_state;

  wb_mem_tester_if #(.DW(DW), .AW(AW)) bus ();

  wb_mem_tester #(.DW(DW), .AW(AW), .BL(BL), .TIMEOUT_CYC(TO_CYC)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start_i       (start),
    .cfg_base_i    (cfg_base),
    .cfg_words_i   (cfg_words),
    .cfg_pattern_i (cfg_pat),
    .init_done_i   (init_done),
    .wb            (bus.master),
    .busy_o        (busy),
    .done_o        (done),
    .pass_o        (pass),
    .err_cnt_o     (err_cnt),
    .fail_addr_o   (fail_addr),
    .fail_data_o   (fail_data),
    .timeout_o     (timeout),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:1023];
  int          max_wait = 0;
  bit          stuck_en = 1'b0;
  bit          ack_en = 1'b1;
  int          wait_cnt = 0;
  logic        slv_ack;
  logic [31:0] slv_rdat;

  always_comb begin
    slv_ack  = bus.wb_cyc_o & bus.wb_stb_o & ack_en & (wait_cnt == 0);
    slv_rdat = mem[bus.wb_addr_o[11:2]];
    if (stuck_en && bus.wb_addr_o == 26'h108) slv_rdat[0] = 1'b1;
  end
  assign bus.wb_ack_i = slv_ack;
  assign bus.wb_dat_i = slv_rdat;

  always @(posedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (slv_ack) begin
        if (bus.wb_we_o) mem[bus.wb_addr_o[11:2]] <= bus.wb_dat_o;
        wait_cnt <= int'($urandom_range(0, max_wait));
      end else if (wait_cnt > 0) begin
        wait_cnt <= wait_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [61:0] exp_q[$];   // {we, cti[2:0], addr[25:0], data[31:0]}
  bit mon_en = 1'b0;
  int gap_ph = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // Expected beats for a full write-then-read run, plus expected errors.
  task automatic build_model(input logic [AW-1:0] base, input int words, input int pat,
                             input bit stk, output int e_err, output logic [AW-1:0] e_fa,
                             output logic [31:0] e_fd);
    logic [AW-1:0] abase, a;
    logic [31:0]   lf, d, rd;
    logic [2:0]    cti;
    int            bstart, blen, pos;
    abase = base & ~26'h3;
    e_err = 0; e_fa = '0; e_fd = '0;
    for (int ph = 0; ph < 2; ph++) begin
      lf = 32'hACE1_2468;
      for (int i = 0; i < words; i++) begin
        bstart = (i / BL) * BL;
        blen   = (words - bstart < BL) ? words - bstart : BL;
        pos    = i - bstart;
        cti    = (blen == 1) ? 3'b000 : ((pos == blen - 1) ? 3'b111 : 3'b010);
        a      = AW'(abase + AW'(i * 4));
        case (pat)
          0:       d = 32'(i);
          1:       d = lf;
          2:       d = 32'h1 << (i % 32);
          default: d = ~32'(i);
        endcase
        exp_q.push_back({(ph == 0), cti, a, d});
        if (ph == 1) begin
          rd = d | ((stk && a == 26'h108) ? 32'h1 : 32'h0);
          if (rd != d) begin
            if (e_err == 0) begin e_fa = a; e_fd = rd; end
            e_err++;
          end
        end
        lf = lfsr_next(lf);
      end
    end
  endtask

  // Bus monitor: every beat, every wait cycle and every inter-burst gap.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [61:0] act, e;
      if (gap_ph == 1) begin
        check("gap_cyc_low", bus.wb_cyc_o, 0);
        gap_ph = (exp_q.size() > 0) ? 2 : 0;
      end else if (gap_ph == 2) begin
        check("gap_one_cycle", bus.wb_cyc_o, 1);
        gap_ph = 0;
      end
      if (bus.wb_stb_o) begin
        check("cyc_with_stb", bus.wb_cyc_o, 1);
        check("sel_all_ones", bus.wb_sel_o, 4'hF);
        check("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e   = exp_q[0];
          act = {bus.wb_we_o, bus.wb_cti_o, bus.wb_addr_o, bus.wb_dat_o};
          if (!e[61]) act[31:0] = e[31:0];  // write data is don't-care on reads
          if (slv_ack) begin
            void'(exp_q.pop_front());
            check("beat", act, e);
            if (e[60:58] != 3'b010) gap_ph = 1;
          end else begin
            check("hold_during_wait", act, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [AW-1:0] base, input int words, input int pat);
    @(negedge clk);
    cfg_base = base; cfg_words = 16'(words); cfg_pat = 2'(pat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one(input logic [AW-1:0] base, input int words, input int pat,
                         input int mw, input bit stk, input int init_dly, input bit poke,
                         input bit e_pass, input int e_err, input logic [AW-1:0] e_fa,
                         input logic [31:0] e_fd);
    int m_err, n;
    logic [AW-1:0] m_fa;
    logic [31:0] m_fd;
    max_wait = mw; stuck_en = stk; init_done = (init_dly == 0);
    exp_q.delete(); gap_ph = 0; mon_en = 1'b1;
    build_model(base, words, pat, stk, m_err, m_fa, m_fd);
    pulse_start(base, words, pat);
    if (words > 0) begin
      check("busy_after_start", busy, 1);
      check("done_cleared", done, 0);
    end
    for (int k = 0; k < init_dly; k++) begin
      check("no_cyc_before_init", bus.wb_cyc_o, 0);
      @(negedge clk);
    end
    init_done = 1'b1;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      if (poke && n == 20) begin
        cfg_base = 26'h800; cfg_words = 16'd3; cfg_pat = 2'(pat + 1); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_in_time", done, 1);
    check("pass", pass, e_pass);
    check("err_cnt", err_cnt, e_err);
    check("fail_addr", fail_addr, e_fa);
    check("fail_data", fail_data, e_fd);
    check("timeout_clear", timeout, 0);
    check("busy_at_done", busy, 0);
    check("all_beats_seen", exp_q.size(), 0);
    @(negedge clk);
    check("done_held", done, 1);
    exp_q.delete();
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            words;
    int            pat;
    int            mw;
    bit            stk;
    int            init_dly;
    bit            poke;
    bit            e_pass;
    int            e_err;
    logic [AW-1:0] e_fa;
    logic [31:0]   e_fd;
  } vec_t;

  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{26'h100,     16, 0, 0, 1'b0, 5, 1'b0, 1'b1, 0, 26'h0,   32'h0};
    vecs[1] = '{26'h103,     10, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0, 26'h0,   32'h0};
    vecs[2] = '{26'h100,     16, 1, 0, 1'b1, 0, 1'b0, 1'b0, 1, 26'h108, 32'h2B38_491B};
    vecs[3] = '{26'h200,     64, 2, 3, 1'b0, 0, 1'b1, 1'b1, 0, 26'h0,   32'h0};
    vecs[4] = '{26'h100,      9, 3, 1, 1'b1, 0, 1'b0, 1'b1, 0, 26'h0,   32'h0};
    vecs[5] = '{26'h100,      0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0, 26'h0,   32'h0};
    vecs[6] = '{26'h3FFFFF0,  8, 1, 2, 1'b0, 0, 1'b0, 1'b1, 0, 26'h0,   32'h0};

    repeat (3) @(negedge clk);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_cyc", bus.wb_cyc_o, 0);

    for (int v = 0; v < 7; v++)
      run_one(vecs[v].base, vecs[v].words, vecs[v].pat, vecs[v].mw, vecs[v].stk,
              vecs[v].init_dly, vecs[v].poke, vecs[v].e_pass, vecs[v].e_err,
              vecs[v].e_fa, vecs[v].e_fd);

    // Randomized runs against the reference model.
    for (int r = 0; r < 6; r++) begin
      logic [AW-1:0] b, fa;
      logic [31:0] fd;
      int w, p, er;
      bit s;
      b = AW'($urandom_range(0, 16'h200));
      w = int'($urandom_range(1, 40));
      p = int'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      exp_q.delete();
      build_model(b, w, p, s, er, fa, fd);
      exp_q.delete();
      run_one(b, w, p, int'($urandom_range(0, 3)), s, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), (er == 0), er, fa, fd);
    end

    // Reset during the third write beat.
    begin
      int acks, n, m_err;
      logic [AW-1:0] m_fa;
      logic [31:0] m_fd;
      max_wait = 0; stuck_en = 1'b1;
      exp_q.delete(); gap_ph = 0; mon_en = 1'b1;
      build_model(26'h100, 16, 1, 1'b1, m_err, m_fa, m_fd);
      pulse_start(26'h100, 16, 1);
      acks = 0; n = 0;
      while (n < 100) begin
        if (bus.wb_stb_o && slv_ack) begin
          if (acks == 2) break;
          acks++;
        end
        @(negedge clk);
        n++;
      end
      check("third_beat_reached", acks, 2);
      mon_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete(); gap_ph = 0;
      check("mid_rst_cyc", bus.wb_cyc_o, 0);
      check("mid_rst_stb", bus.wb_stb_o, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_pass", pass, 0);
      check("mid_rst_err", err_cnt, 0);
      check("mid_rst_fail_addr", fail_addr, 0);
      check("mid_rst_fail_data", fail_data, 0);
      check("mid_rst_timeout", timeout, 0);
      rst = 1'b0;
      run_one(26'h100, 16, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0, 26'h0, 32'h0);
    end

`ifdef WB_MEM_TESTER_TIMEOUT_EN
    // Slave never acknowledges: watchdog aborts after TO_CYC strobe cycles.
    begin
      int stb_cyc, n;
      mon_en = 1'b0; ack_en = 1'b0; init_done = 1'b1;
      pulse_start(26'h100, 4, 0);
      stb_cyc = 0; n = 0;
      while (!done && n < 200) begin
        if (bus.wb_stb_o) stb_cyc++;
        @(negedge clk);
        n++;
      end
      check("to_done", done, 1);
      check("to_stb_cycles", stb_cyc, TO_CYC);
      check("to_cyc_low", bus.wb_cyc_o, 0);
      check("to_flag", timeout, 1);
      check("to_pass", pass, 0);
      ack_en = 1'b1;
      run_one(26'h100, 4, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0, 26'h0, 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule
